muldiv_hilo: RTL
================

// Module: muldiv_hilo
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the single-issue MIPS core.
//  It executes MULT/MULTU/DIV/DIVU plus MTHI/MTLO and sources the MFHI/MFLO value.
//  It sits directly upstream of the 4:1 writeback-select MUX, driving one data input (oHiLo).
//  oBusy drives the pipeline stall logic.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH bits each
// PORTS
//  iClk      in   1      single clock; all state updates on the rising edge
//  iRst      in   1      synchronous, active-high reset
//  iStart    in   1      command valid; sampled only in IDLE
//  iOp       in   3      command: MULT, MULTU, DIV, DIVU, MTHI, MTLO (codes in muldiv_defs.vh)
//  iA        in   WIDTH  rs operand: multiplicand/dividend/MTHI/MTLO data
//  iB        in   WIDTH  rt operand: multiplier/divisor
//  iSelHi    in   1      1 gives oHiLo=HI (MFHI), 0 gives oHiLo=LO (MFLO)
//  oHiLo     out  WIDTH  combinational HI or LO, feeding the writeback MUX
//  oHi/oLo   out  WIDTH  registered HI/LO (debug/trace)
//  oBusy     out  1      registered; 1 while a mul/div is in flight
//  oDone     out  1      registered one-cycle pulse; HI/LO hold the new result this cycle
//  oDivZero  out  1      registered; pulses with oDone when the divisor was 0
// BEHAVIOUR
//  Reset: state=IDLE, HI=LO=0, oBusy=oDone=oDivZero=0, counter=0. Reset dominates every other input.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//   IDLE, iStart=1, MULT/MULTU/DIV/DIVU (edge E0):
//    latch |iA|, |iB| (signed ops) or raw values (unsigned); latch sign flags and op.
//    Go to RUN with count=0; oBusy=1 from E0.
//   IDLE, iStart=1, MTHI/MTLO: write iA to HI/LO at E0 and stay in IDLE.
//    No oBusy and no oDone.
//   RUN: one radix-2 step per edge, for edges E1..E(WIDTH).
//    Multiply: shift-add into a 2*WIDTH accumulator.
//    Divide: restoring shift-subtract.
//    After step WIDTH, go to FIX.
//   FIX (edge E(WIDTH+1)):
//    Apply signs; the quotient is negated if the sign flags differ; the remainder takes the dividend's sign.
//    Product: negated if the sign flags differ.
//    Write HI/LO; oDone=1 for one cycle; oBusy=0; go to IDLE.
//  Latency: the result is visible when oDone=1, in the cycle after E(WIDTH+1).
//   oBusy is high for WIDTH+1 cycles.
//  Mul result: HI=upper WIDTH bits, LO=lower WIDTH bits.
//  Div result: LO=quotient, HI=remainder.
//  Divisor 0: full latency still applies; LO={WIDTH{1'b1}}, HI=original iA; oDivZero=1 with oDone.
//  Signed overflow 0x80000000/-1: LO=0x80000000, HI=0, falling out of the abs arithmetic naturally; no flag.
//  iStart while oBusy=1 (any op, including MTHI/MTLO): ignored. HI/LO are untouched.
//  oHiLo during oBusy: shows the old HI/LO. The pipeline holds MFHI/MFLO on oBusy.
//  iStart in the same cycle as oDone: accepted, because the FSM is already IDLE (back-to-back ops).
//  Reset mid-RUN/FIX: abort next edge; no oDone; HI=LO=0.
// STRUCTURE
//  muldiv_defs.vh holds the shared defines: op codes (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5)
//   and state encodings (IDLE=0, RUN=1, FIX=2).
//  One sub-module, muldiv_step, is combinational: one shift-add or shift-subtract iteration on
//   {acc, operand}, WIDTH-parameterised.
//  The top holds the FSM, counter, sign fix-up, HI/LO registers and the read mux.
// TESTING
//  1. MULTU FFFFFFFF*FFFFFFFF -> HI=FFFFFFFE, LO=00000001.
//     oDone exactly WIDTH+1 edges after the start edge; oBusy high 33 cycles.
//  2. MULT -3*7 -> HI=FFFFFFFF, LO=FFFFFFEB.
//     Then MULT 0x80000000*0x80000000 -> HI=40000000, LO=0.
//  3. DIVU 100/7 -> LO=14, HI=2.
//     DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
//     DIV 7/-2 -> LO=FFFFFFFD, HI=1.
//  4. DIVU 0x1234/0 -> LO=FFFFFFFF, HI=00001234; oDivZero=1 with oDone.
//     DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
//  5. MTHI A5A5A5A5, then MTLO 5A5A5A5A -> iSelHi=1 gives A5A5A5A5, iSelHi=0 gives 5A5A5A5A.
//     MTLO issued during a busy MULT is ignored.
//  6. iRst=1 on RUN step 10 of a MULT -> next cycle oBusy=0, HI=LO=0, no oDone.
//     Back-to-back: iStart on the oDone cycle -> accepted.

Source files
------------

// File: rtl/muldiv_hilo_pkg.sv
// muldiv_hilo_pkg
//   Shared command codes, FSM state encoding and a small op-decode helper
//   for the iterative multiply/divide unit.
package muldiv_hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } opE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } stateE;

  // True for the four commands that need the iterative datapath.
  function automatic logic isArithOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_step.sv
// muldiv_hilo_step
//   One radix-2 iteration on the {accHi, accLo} pair (combinational).
//   Multiply: right-shifting shift-add; accLo holds the multiplier, opnd
//   the multiplicand, the product builds up in {accHi, accLo}.
//   Divide: restoring shift-subtract; accLo holds the dividend and collects
//   quotient bits, accHi holds the partial remainder, opnd the divisor.
// Ports
//   isDiv           in   1 = divide step, 0 = multiply step
//   accHi/accLo     in   current accumulator halves
//   opnd            in   multiplicand or divisor
//   nextHi/nextLo   out  accumulator after this step
module muldiv_hilo_step #(
  parameter int WIDTH = 32
) (
  input  logic             isDiv,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    sum     = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : '0);
    shifted = {accHi, accLo[WIDTH-1]};
    fits    = shifted >= {1'b0, opnd};
    // When the subtract is taken the true result is below opnd, so the
    // modular WIDTH-bit difference is exact.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (isDiv) begin
      nextHi = fits ? diff : shifted[WIDTH-1:0];
      nextLo = {accLo[WIDTH-2:0], fits};
    end else begin
      nextHi = sum[WIDTH:1];
      nextLo = {sum[0], accLo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   Executes MULT/MULTU/DIV/DIVU (WIDTH+1 cycles busy) and MTHI/MTLO
//   (single edge, no busy), and sources the MFHI/MFLO value.
// Ports
//   iClk, iRst       clock, synchronous active-high reset
//   iStart, iOp      command valid / code, sampled only in IDLE
//   iA, iB           rs / rt operands
//   iSelHi           1 selects HI on oHiLo, 0 selects LO
//   oHiLo            combinational HI/LO read for the writeback mux
//   oHi, oLo         registered HI/LO
//   oBusy            1 while a mul/div is in flight
//   oDone            one-cycle pulse, HI/LO hold the new result
//   oDivZero         pulses with oDone when the divisor was 0
//
//   state | meaning
//   IDLE  | waiting for a command; MTHI/MTLO complete here
//   RUN   | WIDTH radix-2 steps, one per edge
//   FIX   | apply signs, write HI/LO, pulse oDone
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic [2:0]       iOp,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iSelHi,
  output logic [WIDTH-1:0] oHiLo,
  output logic [WIDTH-1:0] oHi,
  output logic [WIDTH-1:0] oLo,
  output logic             oBusy,
  output logic             oDone,
  output logic             oDivZero
);

  localparam int CW = $clog2(WIDTH + 1);

  stateE            state, stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] accHi, accLo, opnd, stepHi, stepLo;
  logic [WIDTH-1:0] hiReg, loReg, fixHi, fixLo, absA, absB, quo, rem;
  logic [2*WIDTH-1:0] prod;
  logic             isDiv, negA, negB, divZeroFlag;
  logic             busyNext, doneNext, divZeroNext;
  logic             signedOp;

  muldiv_hilo_step #(.WIDTH(WIDTH)) uStep (
    .isDiv (isDiv),
    .accHi (accHi),
    .accLo (accLo),
    .opnd  (opnd),
    .nextHi(stepHi),
    .nextLo(stepLo)
  );

  always_comb begin
    signedOp = isSignedOp(iOp);
    absA     = (signedOp && iA[WIDTH-1]) ? -iA : iA;
    absB     = (signedOp && iB[WIDTH-1]) ? -iB : iB;
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= ST_IDLE;
    else      state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (iStart && isArithOp(iOp)) stateNext = ST_RUN;
      ST_RUN:  if (count == CW'(WIDTH - 1)) stateNext = ST_FIX;
      ST_FIX:  stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  // Output logic (registered below so the pipeline sees clean flops)
  always_comb begin
    busyNext    = (stateNext != ST_IDLE);
    doneNext    = (state == ST_FIX);
    divZeroNext = (state == ST_FIX) && divZeroFlag;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oDivZero <= 1'b0;
    end else begin
      oBusy    <= busyNext;
      oDone    <= doneNext;
      oDivZero <= divZeroNext;
    end
  end

  // Sign fix-up. 0x80000000 / -1 needs no special case: |q| = 0x80000000
  // negates to itself.
  always_comb begin
    prod = {accHi, accLo};
    if (negA ^ negB) prod = -prod;
    quo = (negA ^ negB) ? -accLo : accLo;
    rem = negA ? -accHi : accHi;
    if (isDiv) begin
      // A zero divisor leaves the dividend in the remainder, so HI comes
      // back as the original rs value once its sign is restored.
      fixHi = rem;
      fixLo = divZeroFlag ? '1 : quo;
    end else begin
      fixHi = prod[2*WIDTH-1:WIDTH];
      fixLo = prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      count       <= '0;
      accHi       <= '0;
      accLo       <= '0;
      opnd        <= '0;
      isDiv       <= 1'b0;
      negA        <= 1'b0;
      negB        <= 1'b0;
      divZeroFlag <= 1'b0;
      hiReg       <= '0;
      loReg       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            if (isArithOp(iOp)) begin
              count       <= '0;
              accHi       <= '0;
              accLo       <= absA;
              opnd        <= absB;
              isDiv       <= (iOp == OP_DIV) || (iOp == OP_DIVU);
              negA        <= signedOp && iA[WIDTH-1];
              negB        <= signedOp && iB[WIDTH-1];
              divZeroFlag <= ((iOp == OP_DIV) || (iOp == OP_DIVU)) && (iB == '0);
            end else if (iOp == OP_MTHI) begin
              hiReg <= iA;
            end else if (iOp == OP_MTLO) begin
              loReg <= iA;
            end
          end
        end
        ST_RUN: begin
          accHi <= stepHi;
          accLo <= stepLo;
          count <= count + CW'(1);
        end
        ST_FIX: begin
          hiReg <= fixHi;
          loReg <= fixLo;
        end
        default: ;
      endcase
    end
  end

  assign oHi   = hiReg;
  assign oLo   = loReg;
  assign oHiLo = iSelHi ? hiReg : loReg;

endmodule
